receiver_rx: RTL and testbench

- Aurora RX-side counterpart of the framed transmitter.
- Takes the RX AXI4-Stream user interface (m_axi_rx_*) and reassembles PACKET_SIZE-bit frames from RX_TDATA_SIZE-bit beats.
- Strips the 8-bit sequence counter from each frame, checks length and sequence, then pushes the INPUT_SIZE-bit payload into the downstream receive FIFO.
- Aurora RX has no tready: the block must accept one beat per cycle, every cycle.

---
 rtl/aurora_pkg.sv | 29 ++
 rtl/rx_frame_assembler.sv | 66 ++++++
 rtl/receiver_rx.sv | 200 ++++++++++++++++++++
 tb/tb_receiver_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// ----------------------------------------------------------------------------
// aurora_pkg
// Definitions shared by the Aurora framed transmitter and receiver.
//   SEQ_BITS             : width of the per-frame sequence counter field
//   DEFAULT_*            : default frame / beat geometry
//   aurora_state_e       : two-state link FSM encoding (idle, running)
//   seq_t                : sequence-number type
//   seq_next()           : sequence increment with natural 8-bit wrap
// ----------------------------------------------------------------------------
package aurora_pkg;

    localparam int unsigned SEQ_BITS             = 8;
    localparam int unsigned DEFAULT_PACKET_SIZE  = 128;
    localparam int unsigned DEFAULT_TDATA_SIZE   = 32;
    localparam int unsigned DEFAULT_COUNTER_BITS = 2;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } aurora_state_e;

    typedef logic [SEQ_BITS-1:0] seq_t;

    // 255 -> 0 falls out of the fixed-width add.
    function automatic seq_t seq_next(input seq_t s);
        return s + seq_t'(1);
    endfunction

endpackage

// File: rtl/rx_frame_assembler.sv
// ----------------------------------------------------------------------------
// rx_frame_assembler
// Shift register that gathers RX beats into a frame, plus a saturating beat
// counter.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   shift_i        : accept beat_i (shift the assembly register left one beat)
//   clear_i        : zero the beat counter (takes priority over counting)
//   beat_i         : incoming beat, inserted at the LSBs
//   frame_next_o   : assembled frame including beat_i (valid when shift_i)
//   count_o        : beats accepted since the last clear, saturating at
//                    PACKET_SIZE/RX_TDATA_SIZE
// Requires at least two beats per frame.
// ----------------------------------------------------------------------------
module rx_frame_assembler #(
    parameter int unsigned PACKET_SIZE   = 128,
    parameter int unsigned RX_TDATA_SIZE = 32,
    parameter int unsigned COUNTER_BITS  = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      shift_i,
    input  logic                      clear_i,
    input  logic [RX_TDATA_SIZE-1:0]  beat_i,
    output logic [PACKET_SIZE-1:0]    frame_next_o,
    output logic [COUNTER_BITS:0]     count_o
);

    localparam int unsigned NUM_BEATS = PACKET_SIZE / RX_TDATA_SIZE;
    localparam int unsigned HistW     = PACKET_SIZE - RX_TDATA_SIZE;
    localparam int unsigned CntW      = COUNTER_BITS + 1;
    localparam logic [CntW-1:0] MaxCount = CntW'(NUM_BEATS);

    // Only the older beats are stored; the newest one comes straight from
    // beat_i so the frame can be judged on the same edge as its last beat.
    logic [HistW-1:0] hist_q, hist_d;
    logic [CntW-1:0]  count_q, count_d;

    assign frame_next_o = {hist_q, beat_i};
    assign count_o      = count_q;

    always_comb begin
        hist_d  = hist_q;
        count_d = count_q;
        if (shift_i) begin
            hist_d = frame_next_o[HistW-1:0];
        end
        if (clear_i) begin
            count_d = '0;
        end else if (shift_i && (count_q != MaxCount)) begin
            // Saturation keeps an over-long frame from wrapping back into a
            // count that would look like a good length.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q  <= '0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/receiver_rx.sv
// ----------------------------------------------------------------------------
// receiver_rx
// Aurora RX framed receiver. Reassembles PACKET_SIZE-bit frames from the RX
// AXI4-Stream user interface, strips and checks the 8-bit sequence field,
// checks the beat count and writes the payload to the receive FIFO.
// There is no back-pressure: one beat per cycle is always accepted.
//
// Ports:
//   user_clk         : clock
//   RST_N            : asynchronous active-low reset
//   start            : level; traffic ignored until sampled high once
//   m_axi_rx_tdata   : beat data, first beat = frame MSBs
//   m_axi_rx_tvalid  : beat valid
//   m_axi_rx_tlast   : last beat of frame
//   din              : payload to FIFO (frame bits [INPUT_SIZE-1:0]), held
//   wr_en            : one-cycle FIFO write strobe
//   full             : FIFO full flag
//   seq_err          : pulse, received sequence differs from expected
//   len_err          : pulse, frame beat count wrong
//   ovf_err          : pulse, good frame dropped because FIFO full
//
// Build option: define SEQ_CHECK_EN to enable the sequence check; without
// it there is no expected-sequence register and seq_err stays 0.
//
// Inputs are registered first; wr_en/din follow two edges after the last
// beat is presented.
// ----------------------------------------------------------------------------
module receiver_rx
    import aurora_pkg::*;
#(
    parameter int unsigned PACKET_SIZE   = DEFAULT_PACKET_SIZE,
    parameter int unsigned RX_TDATA_SIZE = DEFAULT_TDATA_SIZE,
    parameter int unsigned COUNTER_BITS  = DEFAULT_COUNTER_BITS
) (
    input  logic                             user_clk,
    input  logic                             RST_N,
    input  logic                             start,
    input  logic [RX_TDATA_SIZE-1:0]         m_axi_rx_tdata,
    input  logic                             m_axi_rx_tvalid,
    input  logic                             m_axi_rx_tlast,
    output logic [PACKET_SIZE-SEQ_BITS-1:0]  din,
    output logic                             wr_en,
    input  logic                             full,
    output logic                             seq_err,
    output logic                             len_err,
    output logic                             ovf_err
);

    localparam int unsigned NUM_BEATS  = PACKET_SIZE / RX_TDATA_SIZE;
    localparam int unsigned INPUT_SIZE = PACKET_SIZE - SEQ_BITS;
    localparam int unsigned CntW       = COUNTER_BITS + 1;
    // Count before the tlast beat is added; equality means exactly NUM_BEATS.
    localparam logic [CntW-1:0] LastCount = CntW'(NUM_BEATS - 1);

    // Input stage
    logic [RX_TDATA_SIZE-1:0] tdata_q;
    logic                     tvalid_q;
    logic                     tlast_q;
    logic                     full_q;
    logic                     start_q;

    always_ff @(posedge user_clk or negedge RST_N) begin
        if (!RST_N) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            full_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            tdata_q  <= m_axi_rx_tdata;
            tvalid_q <= m_axi_rx_tvalid;
            tlast_q  <= m_axi_rx_tlast;
            full_q   <= full;
            start_q  <= start;
        end
    end

    // Frame assembly
    logic                   asm_shift;
    logic                   asm_clear;
    logic [PACKET_SIZE-1:0] frame_next;
    logic [CntW-1:0]        beat_count;
    seq_t                   rx_seq;

    rx_frame_assembler #(
        .PACKET_SIZE   (PACKET_SIZE),
        .RX_TDATA_SIZE (RX_TDATA_SIZE),
        .COUNTER_BITS  (COUNTER_BITS)
    ) u_assembler (
        .clk_i        (user_clk),
        .rst_ni       (RST_N),
        .shift_i      (asm_shift),
        .clear_i      (asm_clear),
        .beat_i       (tdata_q),
        .frame_next_o (frame_next),
        .count_o      (beat_count)
    );

    assign rx_seq = frame_next[PACKET_SIZE-1 -: SEQ_BITS];

    // Control and checks
    aurora_state_e           state_q, state_d;
    logic [INPUT_SIZE-1:0]   din_q, din_d;
    logic                    wr_en_q, wr_en_d;
    logic                    seq_err_q, seq_err_d;
    logic                    len_err_q, len_err_d;
    logic                    ovf_err_q, ovf_err_d;

`ifdef SEQ_CHECK_EN
    seq_t exp_seq_q, exp_seq_d;
`else
    logic unused_rx_seq;
    assign unused_rx_seq = ^rx_seq;
`endif

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        wr_en_d   = 1'b0;
        seq_err_d = 1'b0;
        len_err_d = 1'b0;
        ovf_err_d = 1'b0;
        asm_shift = 1'b0;
        asm_clear = 1'b0;
`ifdef SEQ_CHECK_EN
        exp_seq_d = exp_seq_q;
`endif

        unique case (state_q)
            StIdle: begin
                // Beats seen while idle are dropped; count is kept at zero.
                asm_clear = 1'b1;
                if (start_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (tvalid_q) begin
                    asm_shift = 1'b1;
                    if (tlast_q) begin
                        asm_clear = 1'b1;
                        if (beat_count != LastCount) begin
                            len_err_d = 1'b1;
                        end else begin
`ifdef SEQ_CHECK_EN
                            seq_err_d = (rx_seq != exp_seq_q);
                            // Resync to whatever arrived, not to the old guess.
                            exp_seq_d = seq_next(rx_seq);
`endif
                            if (full_q) begin
                                ovf_err_d = 1'b1;
                            end else begin
                                wr_en_d = 1'b1;
                                din_d   = frame_next[INPUT_SIZE-1:0];
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge user_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            din_q     <= '0;
            wr_en_q   <= 1'b0;
            seq_err_q <= 1'b0;
            len_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            wr_en_q   <= wr_en_d;
            seq_err_q <= seq_err_d;
            len_err_q <= len_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

`ifdef SEQ_CHECK_EN
    always_ff @(posedge user_clk or negedge RST_N) begin
        if (!RST_N) begin
            exp_seq_q <= '0;
        end else begin
            exp_seq_q <= exp_seq_d;
        end
    end
`endif

    assign din     = din_q;
    assign wr_en   = wr_en_q;
    assign seq_err = seq_err_q;
    assign len_err = len_err_q;
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_receiver_rx.sv
// ----------------------------------------------------------------------------
// tb_receiver_rx
// Self-checking bench for receiver_rx. A per-cycle stimulus list is driven
// into the DUT while a frame-level reference model (beat queue, plain
// arithmetic) predicts the status pulses and din for every cycle.
// ----------------------------------------------------------------------------
module tb_receiver_rx;

    localparam int NB = 4;

    logic         user_clk = 1'b0;
    logic         RST_N    = 1'b0;
    logic         start    = 1'b0;
    logic [31:0]  tdata    = '0;
    logic         tvalid   = 1'b0;
    logic         tlast    = 1'b0;
    logic         full     = 1'b0;
    logic [119:0] din;
    logic         wr_en;
    logic         seq_err;
    logic         len_err;
    logic         ovf_err;

    receiver_rx dut (
        .user_clk        (user_clk),
        .RST_N           (RST_N),
        .start           (start),
        .m_axi_rx_tdata  (tdata),
        .m_axi_rx_tvalid (tvalid),
        .m_axi_rx_tlast  (tlast),
        .din             (din),
        .wr_en           (wr_en),
        .full            (full),
        .seq_err         (seq_err),
        .len_err         (len_err),
        .ovf_err         (ovf_err)
    );

    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          start;
        bit          valid;
        bit          last;
        bit          full;
        logic [31:0] data;
    } stim_t;

    stim_t       stim_q[$];
    bit          cur_start;
    logic [7:0]  gen_seq;

    // Reference model state
    bit          m_started;
    logic [31:0] m_beats[$];
    logic [7:0]  m_exp_seq;
    logic [119:0] m_din;

    // Status vector order: {wr_en, seq_err, len_err, ovf_err}
    bit          have_prev;
    logic [3:0]  prev_st;
    logic [119:0] prev_din;

    task automatic model_reset();
        m_started = 1'b0;
        m_beats.delete();
        m_exp_seq = 8'd0;
        m_din     = '0;
        have_prev = 1'b0;
    endtask

    task automatic model_step(input stim_t s, output logic [3:0] st);
        logic [127:0] frame;
        logic [7:0]   seq;
        st = 4'b0000;
        if (m_started && s.valid) begin
            m_beats.push_back(s.data);
            if (s.last) begin
                if (m_beats.size() != NB) begin
                    st[1] = 1'b1;
                end else begin
                    frame = {m_beats[0], m_beats[1], m_beats[2], m_beats[3]};
                    seq   = frame[127:120];
`ifdef SEQ_CHECK_EN
                    if (seq != m_exp_seq) st[2] = 1'b1;
`endif
                    m_exp_seq = seq + 8'd1;
                    if (s.full) begin
                        st[0] = 1'b1;
                    end else begin
                        st[3] = 1'b1;
                        m_din = frame[119:0];
                    end
                end
                m_beats.delete();
            end
        end
        if (s.start) m_started = 1'b1;
    endtask

    task automatic push(input bit v, input bit l, input bit f, input logic [31:0] d);
        stim_t s;
        s.start = cur_start;
        s.valid = v;
        s.last  = l;
        s.full  = f;
        s.data  = d;
        stim_q.push_back(s);
    endtask

    task automatic add_idle(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            push(1'b0, r[0], 1'b0, r);
        end
    endtask

    task automatic add_frame(input int nb, input logic [7:0] seq, input bit f, input int gap_pct);
        logic [31:0] r;
        logic [31:0] g;
        for (int i = 0; i < nb; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                g = $urandom();
                push(1'b0, g[1], f, g);
            end
            r = $urandom();
            if (i == 0) r = {seq, r[23:0]};
            push(1'b1, (i == nb - 1), f, r);
        end
    endtask

    task automatic add_tp_frame();
        push(1'b1, 1'b0, 1'b0, 32'h00AABBCC);
        push(1'b1, 1'b0, 1'b0, 32'h11223344);
        push(1'b1, 1'b0, 1'b0, 32'h55667788);
        push(1'b1, 1'b1, 1'b0, 32'h99AABBCC);
    endtask

    task automatic run_stim();
        stim_t s;
        while (stim_q.size() > 0) begin
            s      = stim_q.pop_front();
            start  = s.start;
            tvalid = s.valid;
            tlast  = s.last;
            full   = s.full;
            tdata  = s.data;
            @(posedge user_clk);
            #1;
            if (have_prev) begin
                check_eq("status", {wr_en, seq_err, len_err, ovf_err}, prev_st);
                check_eq("din", din, prev_din);
            end
            model_step(s, prev_st);
            prev_din  = m_din;
            have_prev = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_status"}, {wr_en, seq_err, len_err, ovf_err}, 4'b0000);
        check_eq({tag, "_din"}, din, 120'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cur_start = 1'b0;
        gen_seq   = 8'd0;
        model_reset();

        // Power-on reset
        repeat (2) @(posedge user_clk);
        #1;
        check_reset_outputs("por");
        RST_N = 1'b1;

        // Traffic before start is ignored; start arrives on an idle cycle
        add_frame(4, 8'd0, 1'b0, 0);
        add_frame(2, 8'd0, 1'b0, 0);
        add_idle(2);
        cur_start = 1'b1;
        add_idle(1);
        add_tp_frame();
        add_idle(3);
        run_stim();
        check_eq("tp_din", din, 120'hAABBCC_11223344_55667788_99AABBCC);

        // Back-to-back frames, no idle cycles
        add_frame(4, 8'd1, 1'b0, 0);
        add_frame(4, 8'd2, 1'b0, 0);
        add_frame(4, 8'd3, 1'b0, 0);
        add_idle(2);

        // Sequence jump then resync; start deasserted has no effect
        cur_start = 1'b0;
        add_frame(4, 8'd5, 1'b0, 0);
        add_frame(4, 8'd6, 1'b0, 0);
        add_idle(2);

        // Length errors: short, long, five beats, then a good frame
        add_frame(3, 8'd7, 1'b0, 0);
        add_frame(6, 8'd7, 1'b0, 0);
        add_frame(5, 8'd7, 1'b0, 0);
        add_frame(4, 8'd7, 1'b0, 0);
        add_idle(1);

        // Overflow, len_err with full, sequence wrap 255 -> 0
        add_frame(4, 8'd8, 1'b1, 0);
        add_frame(3, 8'd9, 1'b1, 0);
        add_frame(4, 8'd255, 1'b0, 0);
        add_frame(4, 8'd0, 1'b0, 0);
        add_idle(2);
        run_stim();

        // Randomised traffic with stalls, errors and full
        gen_seq = 8'd1;
        for (int k = 0; k < 60; k++) begin
            int   nb;
            bit   f;
            logic [7:0] sq;
            nb = ($urandom_range(9) < 8) ? NB : int'($urandom_range(6, 1));
            f  = ($urandom_range(99) < 15);
            if ($urandom_range(9) == 0) begin
                sq = 8'($urandom());
            end else begin
                sq = gen_seq;
            end
            if (nb == NB) gen_seq = sq + 8'd1;
            add_frame(nb, sq, f, 20);
            if ($urandom_range(3) == 0) add_idle(int'($urandom_range(3, 1)));
        end
        add_idle(2);
        run_stim();

        // Reset in the middle of a frame
        add_frame(4, gen_seq, 1'b0, 0);
        push(1'b1, 1'b0, 1'b0, 32'h0BADF00D);
        push(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        run_stim();
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge user_clk);
        #1;
        RST_N = 1'b1;
        model_reset();

        // Must need start again; then a clean frame
        cur_start = 1'b0;
        add_frame(4, 8'd0, 1'b0, 0);
        cur_start = 1'b1;
        add_idle(1);
        add_tp_frame();
        add_idle(3);
        run_stim();
        check_eq("post_rst_din", din, 120'hAABBCC_11223344_55667788_99AABBCC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
